vga_pattern_gen: RTL and testbench

Parametrised VGA test-pattern generator. Consumes pixel coordinates and active-video enable from the VGA timing block at 25 MHz, produces one registered RGB word per pixel, and replaces the fixed five-bar colour generator. It supports four run-time modes: N-bar colour bars, checkerboard, bouncing box and frame-timed colour cycling. Mode changes take effect only at frame boundaries, so the displayed image never tears.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_box_mover.sv | 61 ++++++
 rtl/vga_pattern_gen.sv | 115 +++++++++++
 tb/tb_vga_pattern_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared colour constants, palette and mode encoding for the VGA test-pattern generator.
// Colours are 12-bit {R,G,B}, 4 bits per channel.
package vga_pkg;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] BLUE  = 12'h00F;

  // All sixteen entries are distinct so every bar and cycle step is visible.
  localparam logic [11:0] PALETTE [16] = '{
    WHITE, 12'hFF0, 12'h0FF, GREEN, 12'hF0F, RED, BLUE, 12'h888,
    12'hF80, 12'h08F, 12'h8F0, 12'hF08, 12'h444, 12'hCCC, 12'h80F, 12'h0F8
  };

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_CYCLE = 2'd3
  } mode_e;

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: one step per frame on each axis, reversing at the limits
// so the box never leaves the screen and never stalls.
module vga_box_mover #(
  parameter int H_DISP   = 640,
  parameter int V_DISP   = 480,
  parameter int BOX_SIZE = 32
)(
  input  logic       clk_25,
  input  logic       rst,
  input  logic       advance,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [9:0] X_MAX = 10'(H_DISP - BOX_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_DISP - BOX_SIZE);

  logic dir_x, dir_y;  // 1 = moving towards larger coordinates

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (advance) begin
      // On reaching a limit the flip and the step away happen in the same update.
      if (dir_x) begin
        if (box_x == X_MAX) begin
          dir_x <= 1'b0;
          box_x <= box_x - 10'd1;
        end else begin
          box_x <= box_x + 10'd1;
        end
      end else begin
        if (box_x == '0) begin
          dir_x <= 1'b1;
          box_x <= box_x + 10'd1;
        end else begin
          box_x <= box_x - 10'd1;
        end
      end
      if (dir_y) begin
        if (box_y == Y_MAX) begin
          dir_y <= 1'b0;
          box_y <= box_y - 10'd1;
        end else begin
          box_y <= box_y + 10'd1;
        end
      end else begin
        if (box_y == '0) begin
          dir_y <= 1'b1;
          box_y <= box_y + 10'd1;
        end else begin
          box_y <= box_y - 10'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: colour bars, checkerboard, bouncing box and palette cycling,
// one registered RGB word per pixel; the mode is latched at the first pixel of each frame.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_DISP     = 640,
  parameter int V_DISP     = 480,
  parameter int NUM_BARS   = 8,
  parameter int CELL_LOG2  = 5,
  parameter int BOX_SIZE   = 32,
  parameter int CYCLE_LOG2 = 6,
  parameter int RGB_W      = 4
)(
  input  logic               clk_25,
  input  logic               rst,
  input  logic [9:0]         pixel_xpos,
  input  logic [9:0]         pixel_ypos,
  input  logic               de,
  input  logic [1:0]         mode_sel,
  output logic [3*RGB_W-1:0] pixel_data,
  output logic               frame_tick
);

  localparam int          BAR_W    = H_DISP / NUM_BARS;
  localparam logic [9:0]  X_LAST   = 10'(H_DISP - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_DISP - 1);
  localparam logic [9:0]  BAR_LAST = 10'(BAR_W - 1);
  localparam logic [3:0]  IDX_LAST = 4'(NUM_BARS - 1);
  localparam logic [10:0] H_LIM    = 11'(H_DISP);
  localparam logic [10:0] V_LIM    = 11'(V_DISP);
  localparam logic [10:0] BOX_EXT  = 11'(BOX_SIZE);

  // Stretch each 4-bit channel to RGB_W bits by repeating its bit pattern.
  function automatic logic [3*RGB_W-1:0] expand(input logic [11:0] c);
    logic [3*RGB_W-1:0] o;
    o = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < RGB_W; i++)
        o[ch*RGB_W + i] = c[ch*4 + 3 - ((RGB_W - 1 - i) % 4)];
    return o;
  endfunction

  mode_e       mode_q, cur_mode;
  logic [9:0]  bar_cnt, cur_cnt;
  logic [3:0]  bar_idx, cur_idx, pal_idx;
  logic [CYCLE_LOG2-1:0] frame_cnt;
  logic [9:0]  box_x, box_y;
  logic [11:0] rgb;
  logic        frame_start, last_px, in_range, in_box;

  assign frame_start = de && pixel_xpos == '0 && pixel_ypos == '0;
  assign last_px     = de && pixel_xpos == X_LAST && pixel_ypos == Y_LAST;
  assign in_range    = {1'b0, pixel_xpos} < H_LIM && {1'b0, pixel_ypos} < V_LIM;
  assign in_box      = pixel_xpos >= box_x && {1'b0, pixel_xpos} < {1'b0, box_x} + BOX_EXT &&
                       pixel_ypos >= box_y && {1'b0, pixel_ypos} < {1'b0, box_y} + BOX_EXT;

  always_comb begin
    // The first pixel of a frame already renders in the newly requested mode.
    cur_mode = frame_start ? mode_e'(mode_sel) : mode_q;
    cur_cnt  = (pixel_xpos == '0) ? '0 : bar_cnt;
    cur_idx  = (pixel_xpos == '0) ? '0 : bar_idx;
    rgb      = BLACK;
    if (de && in_range) begin
      case (cur_mode)
        MODE_BARS:  rgb = PALETTE[cur_idx];
        MODE_CHECK: rgb = (pixel_xpos[CELL_LOG2] ^ pixel_ypos[CELL_LOG2]) ? BLACK : WHITE;
        MODE_BOX:   rgb = in_box ? RED : BLUE;
        default:    rgb = PALETTE[pal_idx];
      endcase
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      pixel_data <= '0;
      frame_tick <= 1'b0;
      mode_q     <= MODE_BARS;
      bar_cnt    <= '0;
      bar_idx    <= '0;
      frame_cnt  <= '0;
      pal_idx    <= '0;
    end else begin
      pixel_data <= expand(rgb);
      frame_tick <= last_px;
      if (frame_start) mode_q <= mode_e'(mode_sel);
      // Bar index tracked by a running pixel counter; the last bar absorbs the remainder.
      if (de) begin
        if (cur_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          bar_idx <= (cur_idx < IDX_LAST) ? cur_idx + 4'd1 : cur_idx;
        end else begin
          bar_cnt <= cur_cnt + 10'd1;
          bar_idx <= cur_idx;
        end
      end
      if (last_px) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (&frame_cnt) pal_idx <= pal_idx + 4'd1;
      end
    end
  end

  vga_box_mover #(
    .H_DISP   (H_DISP),
    .V_DISP   (V_DISP),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .clk_25  (clk_25),
    .rst     (rst),
    .advance (last_px),
    .box_x   (box_x),
    .box_y   (box_y)
  );

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a small screen: per-cycle comparison against a
// closed-form pattern model, plus literal pixel pins for specific frames.
module tb_vga_pattern_gen;
  import vga_pkg::*;

  localparam int H = 32, V = 12, NB = 6, CL = 2, BS = 4, CY = 2, RW = 4;
  localparam int BW = H / NB;

  logic          clk_25 = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    pixel_xpos = '0, pixel_ypos = '0;
  logic          de = 1'b0;
  logic [1:0]    mode_sel = '0;
  logic [3*RW-1:0] pixel_data;
  logic          frame_tick;

  int total = 0, bad = 0;
  int ticks = 0, mq = 0;
  logic [11:0] pix_log [0:V-1][0:H-1];

  vga_pattern_gen #(
    .H_DISP(H), .V_DISP(V), .NUM_BARS(NB), .CELL_LOG2(CL),
    .BOX_SIZE(BS), .CYCLE_LOG2(CY), .RGB_W(RW)
  ) dut (
    .clk_25(clk_25), .rst(rst), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .de(de), .mode_sel(mode_sel), .pixel_data(pixel_data), .frame_tick(frame_tick)
  );

  always #20 clk_25 = ~clk_25;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Box position after t frame ticks: triangle wave between 0 and mx.
  function automatic int tri_pos(input int t, input int mx);
    int p;
    p = t % (2 * mx);
    return (p <= mx) ? p : 2 * mx - p;
  endfunction

  function automatic logic [11:0] model_px(input int x, input int y, input bit d,
                                           input int m, input int t);
    int idx, bx, by;
    if (!d) return 12'h000;
    if (x >= H || y >= V) return BLACK;
    case (m)
      0: begin
        idx = x / BW;
        if (idx > NB - 1) idx = NB - 1;
        return PALETTE[idx];
      end
      1: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? BLACK : WHITE;
      2: begin
        bx = tri_pos(t, H - BS);
        by = tri_pos(t, V - BS);
        return (x >= bx && x < bx + BS && y >= by && y < by + BS) ? RED : BLUE;
      end
      default: return PALETTE[(t >> CY) % 16];
    endcase
  endfunction

  // Compare process: model state advances on each clock edge, outputs checked 2 time units later.
  initial begin
    int sx, sy, ms;
    bit sd, fs, lp;
    logic [11:0] expd;
    bit expt;
    forever begin
      @(posedge clk_25);
      sx = int'(pixel_xpos); sy = int'(pixel_ypos); sd = de; ms = int'(mode_sel);
      if (rst) begin
        ticks = 0; mq = 0; expd = '0; expt = 1'b0;
      end else begin
        fs = sd && sx == 0 && sy == 0;
        if (fs) mq = ms;
        expd = model_px(sx, sy, sd, mq, ticks);
        lp = sd && sx == H - 1 && sy == V - 1;
        expt = lp;
        if (lp) ticks++;
      end
      #2;
      chk("pixel", 32'(pixel_data), 32'(expd));
      chk("frame_tick", 32'(frame_tick), 32'(expt));
      chk("box_x", 32'(dut.u_box.box_x), 32'(tri_pos(ticks, H - BS)));
      chk("box_y", 32'(dut.u_box.box_y), 32'(tri_pos(ticks, V - BS)));
      chk("pal_idx", 32'(dut.pal_idx), 32'((ticks >> CY) % 16));
      if (sd && sx < H && sy < V) pix_log[sy][sx] = pixel_data;
    end
  end

  task automatic px(input int x, input int y, input bit d);
    @(posedge clk_25);
    #1;
    de = d;
    pixel_xpos = 10'(x);
    pixel_ypos = 10'(y);
  endtask

  task automatic blank(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) px(H + int'($urandom_range(0, 7)), int'($urandom_range(0, V - 1)), 1'b1);
      else px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
    end
  endtask

  // One full frame; mode m0 at start, switching to m1 from line sw; rnd adds random mode/blanking.
  task automatic run_frame(input int m0, input int sw, input int m1, input bit rnd);
    mode_sel = 2'(m0);
    for (int y = 0; y < V; y++) begin
      if (y == sw) mode_sel = 2'(m1);
      for (int x = 0; x < H; x++) begin
        if (rnd && $urandom_range(0, 63) == 0) mode_sel = 2'($urandom_range(0, 3));
        px(x, y, 1'b1);
      end
      blank(rnd ? int'($urandom_range(0, 3)) : 1, rnd);
    end
    blank(rnd ? int'($urandom_range(0, 4)) : 2, rnd);
  endtask

  task automatic pin(input string nm, input int x, input int y, input logic [11:0] exp);
    chk(nm, 32'(pix_log[y][x]), 32'(exp));
  endtask

  initial begin
    repeat (3) @(posedge clk_25);
    #1;
    chk("reset_pixel", 32'(pixel_data), 32'h0);
    chk("reset_tick", 32'(frame_tick), 32'h0);
    #4 rst = 1'b0;

    run_frame(0, -1, 0, 1'b0);
    pin("bar_x0", 0, 0, 12'hFFF);
    pin("bar_x4", 4, 0, 12'hFFF);
    pin("bar_x5", 5, 0, 12'hFF0);
    pin("bar_x24", 24, 3, 12'hF0F);
    pin("bar_x25", 25, 3, 12'hF00);
    pin("bar_x31", 31, 11, 12'hF00);

    run_frame(0, 5, 1, 1'b0);
    pin("bars_hold", 10, 8, 12'h0FF);
    run_frame(1, -1, 1, 1'b0);
    pin("chk_0_0", 0, 0, 12'hFFF);
    pin("chk_4_0", 4, 0, 12'h000);
    pin("chk_4_4", 4, 4, 12'hFFF);
    pin("chk_4_8", 4, 8, 12'h000);

    run_frame(2, -1, 2, 1'b0);
    pin("box_in_tl", 3, 3, 12'hF00);
    pin("box_in_br", 6, 6, 12'hF00);
    pin("box_out_r", 7, 6, 12'h00F);
    pin("box_out_l", 2, 3, 12'h00F);
    run_frame(3, -1, 3, 1'b0);
    pin("cycle_pal1", 0, 0, 12'hFF0);

    // Reset in the middle of line 6 of a box frame.
    mode_sel = 2'd2;
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < H && !(y == 6 && x > 10); x++) px(x, y, 1'b1);
    @(posedge clk_25);
    #5;
    rst = 1'b1;
    de = 1'b0;
    #1;
    chk("midrst_pixel", 32'(pixel_data), 32'h0);
    chk("midrst_box_x", 32'(dut.u_box.box_x), 32'h0);
    chk("midrst_box_y", 32'(dut.u_box.box_y), 32'h0);
    chk("midrst_tick", 32'(frame_tick), 32'h0);
    repeat (2) @(posedge clk_25);
    #5 rst = 1'b0;
    run_frame(0, -1, 0, 1'b0);
    pin("post_rst_x0", 0, 0, 12'hFFF);
    pin("post_rst_x5", 5, 0, 12'hFF0);

    for (int f = 0; f < 66; f++) run_frame(int'($urandom_range(0, 3)), -1, 0, 1'b1);
    repeat (2) @(posedge clk_25);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
